// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and helpers for the seven-segment display arbiter
//
// Purpose: FSM state enum, digit/nibble typedefs and the fixed-priority pick
// used by seg7_display_arbiter and seg7_digit_mask.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0]                  nibble_t;
    typedef nibble_t [NUM_DIGITS-1:0]    digit_vec_t;
    typedef logic [NUM_DIGITS-1:0]       digit_en_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        OPEN = 2'd2
    } seg7_state_t;

    // Index of the lowest set bit (highest priority requester), -1 when none.
    function automatic int lowest_set_index(input logic [31:0] req);
        int idx;
        idx = -1;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_digit_mask.sv
// rtl/seg7_digit_mask.sv - digit enable generation with leading-zero blanking and blink
//
// Purpose: combinational digit-enable mask for the latched display value.
// Ports:
//   i_value      latched 4-nibble value, nibble k drives digit k
//   i_lz_blank   suppress leading zero digits (digit 0 is never blanked)
//   i_blink_off  blink off-phase, forces every enable low
//   o_digit_en   per-digit enables
module seg7_digit_mask
    import seg7_pkg::*;
(
    input  digit_vec_t i_value,
    input  logic       i_lz_blank,
    input  logic       i_blink_off,
    output digit_en_t  o_digit_en
);

    logic      w_seen;
    digit_en_t w_keep;

    // Walk from the most significant digit down; a digit survives blanking
    // once any nibble at or above it is non-zero.
    always_comb begin
        w_seen = 1'b0;
        w_keep = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_seen    = w_seen | (|i_value[k]);
            w_keep[k] = w_seen | (k == 0);
        end
    end

    always_comb begin
        o_digit_en = '1;
        if (i_lz_blank) begin
            o_digit_en = w_keep;
        end
        if (i_blink_off) begin
            o_digit_en = '0;
        end
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// rtl/seg7_display_arbiter.sv - fixed-priority owner arbitration for the 4-digit display
//
// Purpose: grants the display to one requester (index 0 highest priority) for at
// least MIN_HOLD cycles, latches the owner's value and drives registered digit
// enables/values with per-owner leading-zero blanking and blinking.
// Ports:
//   clk_1k_i                   1 kHz display clock
//   rst_ni                     asynchronous active-low reset
//   req_i                      per-requester level request
//   value_i                    per-requester 16-bit value, requester i at [16*i +: 16]
//   lz_blank_i / blink_i       per-requester blanking / blink enables
//   gnt_o, busy_o              one-hot owner, any-owner flag
//   digitN_en_o, digitN_o      digit enable / value to the driver
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int MIN_HOLD   = 500,
    parameter int BLINK_HALF = 250
) (
    input  logic                   clk_1k_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*16-1:0]  value_i,
    input  logic [NUM_REQ-1:0]     lz_blank_i,
    input  logic [NUM_REQ-1:0]     blink_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic                   busy_o,
    output logic                   digit0_en_o,
    output logic                   digit1_en_o,
    output logic                   digit2_en_o,
    output logic                   digit3_en_o,
    output logic [3:0]             digit0_o,
    output logic [3:0]             digit1_o,
    output logic [3:0]             digit2_o,
    output logic [3:0]             digit3_o
);

    localparam int HOLD_W  = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam int BLINK_W = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MIN_HOLD - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_MID  = BLINK_W'(BLINK_HALF);

    // With a one-cycle hold the grant cycle itself already satisfies the hold.
    localparam seg7_state_t GRANT_STATE = (MIN_HOLD == 1) ? OPEN : HOLD;

    seg7_state_t          r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_busy;
    logic [HOLD_W-1:0]    r_hold;
    logic [BLINK_W-1:0]   r_blink;
    digit_vec_t           r_value;
    digit_en_t            r_digit_en;
    digit_vec_t           r_digits;

    seg7_state_t          w_state_nxt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic [BLINK_W-1:0]   w_blink_nxt;
    digit_vec_t           w_value_nxt;
    logic                 w_busy_nxt;
    int                   w_win_idx;
    logic [NUM_REQ-1:0]   w_win;
    digit_vec_t           w_owner_val;
    logic                 w_owner_lz;
    logic                 w_owner_blink;
    logic                 w_blink_off;
    digit_en_t            w_mask_en;

    assign w_win_idx = lowest_set_index(32'(req_i));

    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == i) begin
                w_win[i] = 1'b1;
            end
        end
    end

    // r_hold/r_blink hold the counts belonging to the cycle currently shown,
    // so a fresh grant shows count 0 (hold start, blink on-phase).
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_hold_nxt  = r_hold;
        w_blink_nxt = (r_blink == BLINK_LAST) ? '0 : r_blink + BLINK_W'(1);
        case (r_state)
            IDLE: begin
                w_hold_nxt  = '0;
                w_blink_nxt = '0;
                if (|req_i) begin
                    w_gnt_nxt   = w_win;
                    w_state_nxt = GRANT_STATE;
                end
            end
            HOLD: begin
                w_hold_nxt = r_hold + HOLD_W'(1);
                if (w_hold_nxt == HOLD_LAST) begin
                    w_state_nxt = OPEN;
                end
            end
            OPEN: begin
                if (!(|req_i)) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_blink_nxt = '0;
                end else if (w_win != r_gnt) begin
                    w_state_nxt = GRANT_STATE;
                    w_gnt_nxt   = w_win;
                    w_hold_nxt  = '0;
                    w_blink_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
                w_blink_nxt = '0;
            end
        endcase
    end

    // Per-owner selects follow the next owner so outputs move with gnt_o.
    always_comb begin
        w_owner_val   = '0;
        w_owner_lz    = 1'b0;
        w_owner_blink = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_nxt[i]) begin
                w_owner_val   = value_i[16*i +: 16];
                w_owner_lz    = lz_blank_i[i];
                w_owner_blink = blink_i[i];
            end
        end
    end

    // An owner that dropped its request during HOLD keeps its last value.
    assign w_value_nxt = (|(w_gnt_nxt & req_i)) ? w_owner_val : r_value;
    assign w_busy_nxt  = |w_gnt_nxt;
    assign w_blink_off = w_owner_blink && (w_blink_nxt >= BLINK_MID);

    seg7_digit_mask u_digit_mask (
        .i_value     (w_value_nxt),
        .i_lz_blank  (w_owner_lz),
        .i_blink_off (w_blink_off),
        .o_digit_en  (w_mask_en)
    );

    always_ff @(posedge clk_1k_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_hold     <= '0;
            r_blink    <= '0;
            r_value    <= '0;
            r_digit_en <= '0;
            r_digits   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_busy     <= w_busy_nxt;
            r_hold     <= w_hold_nxt;
            r_blink    <= w_blink_nxt;
            r_value    <= w_value_nxt;
            r_digit_en <= w_busy_nxt ? w_mask_en : '0;
            r_digits   <= w_busy_nxt ? w_value_nxt : '0;
        end
    end

    assign gnt_o       = r_gnt;
    assign busy_o      = r_busy;
    assign digit0_en_o = r_digit_en[0];
    assign digit1_en_o = r_digit_en[1];
    assign digit2_en_o = r_digit_en[2];
    assign digit3_en_o = r_digit_en[3];
    assign digit0_o    = r_digits[0];
    assign digit1_o    = r_digits[1];
    assign digit2_o    = r_digits[2];
    assign digit3_o    = r_digits[3];

endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Shares the single 4-digit seven-segment display between several producers (score, timer, status message, …) and drives the digit-enable/digit-value inputs of the Basys3 seven-segment driver. It grants the display to one requester at a time under fixed priority with a guaranteed minimum display time, latches the owner's 16-bit hex value, and applies per-owner leading-zero blanking and blinking. It sits between the application logic and the display driver, in the same 1 kHz clock domain.

## Interface
- NUM_REQ, 3, number of requesters; index 0 has the highest priority.
- MIN_HOLD, 500, minimum cycles one grant lasts before another requester can take the display (0.5 s at 1 kHz); must be ≥1.
- BLINK_HALF, 250, cycles per blink on-phase and per off-phase; must be ≥1.
- clk_1k_i  in  1  1 kHz display clock; the only clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-requester display request, level-sensitive.
- value_i  in  NUM_REQ×16  per-requester hex value; nibble k goes to digit k.
- lz_blank_i  in  NUM_REQ  per-requester enable for leading-zero blanking.
- blink_i  in  NUM_REQ  per-requester enable for blinking.
- gnt_o  out  NUM_REQ  one-hot current owner; all zero when idle.
- busy_o  out  1  high while any grant is active.
- digit0_en_o…digit3_en_o  out  1 each  digit enable to the driver.
- digit0_o…digit3_o  out  4 each  digit value to the driver.

## Operation
- FSM states:
  - IDLE: no owner.
  - HOLD: owner granted, hold counter below MIN_HOLD-1.
  - OPEN: hold has expired; the owner keeps the display until a new arbitration.
- IDLE: if any req_i is high, grant the lowest set index and go to HOLD. The hold counter starts at 0 and the blink counter starts at 0.
- HOLD: the hold counter increments each cycle. Neither a higher-priority request nor the owner dropping req_i ends the grant. On the cycle the counter reaches MIN_HOLD-1, go to OPEN.
- OPEN: re-arbitrate every cycle.
  - No req_i high: go to IDLE and clear gnt_o.
  - The winner (lowest set index) equals the current owner: stay in OPEN, no change.
  - The winner differs from the owner: switch gnt_o, go to HOLD, clear the hold counter and the blink counter.
- Value latch: while the owner's req_i is high, the latch captures value_i[owner] every cycle. While the owner's req_i is low (only possible in HOLD), the latch keeps its last value.
- Leading-zero blanking (owner's lz_blank_i high): digit k (k=3..1) is disabled if the latched nibble k and every higher nibble are all zero. Digit 0 is always enabled. Example: 16'h0000 shows only digit 0.
- Blink (owner's blink_i high): the blink counter counts 0 to 2·BLINK_HALF-1 and wraps. While the counter is ≥ BLINK_HALF, all enables are forced to 0. Digit values are unaffected.
- IDLE: all enables are 0 and all digit values are 0.

## Timing
- Reset values: gnt_o=0, busy_o=0, all digitN_en_o=0, all digitN_o=0, state IDLE, all counters 0. Reset asserted mid-grant takes effect immediately (asynchronously).
- All outputs are registered.
- gnt_o, busy_o, digit enables and digit values change together, one cycle after the sampling edge.
- A request seen in IDLE is displayed on the next cycle.
- A value_i change by the owner appears on the outputs one cycle later.
- A grant lasts at least MIN_HOLD cycles, counted from the first cycle gnt_o is asserted.
- Simultaneous requests: the lowest index wins.
- An owner releasing on the same edge a new requester rises: in OPEN, the new requester is granted directly with no IDLE cycle.
- Blink after a grant change: the first BLINK_HALF cycles are visible (on-phase).

## Structure
- Package seg7_pkg holds:
  - the FSM state enum (IDLE, HOLD, OPEN);
  - NUM_DIGITS=4;
  - the nibble and digit-vector typedefs;
  - a function that computes the lowest-set-index priority pick.
- One combinational sub-module, seg7_digit_mask. It takes the latched 16-bit value, lz_blank and blink_off, and returns the 4 digit enables.
- The counters use $clog2(MIN_HOLD) and $clog2(2·BLINK_HALF) bits. The hold counter saturates and does not wrap.

## Test plan
All scenarios use MIN_HOLD=4 and BLINK_HALF=2.
- Reset → all outputs 0. req_i=3'b010 with value 16'h1234 → next cycle gnt_o=3'b010, busy_o=1, digits 4,3,2,1, all enables 1.
- req_i=3'b110 from IDLE → gnt_o=3'b010. Owner req 1 high from cycle 0 and req 0 raised at cycle 1 → grant moves to index 0 exactly 4 cycles after the first grant, not earlier.
- Owner drops req at cycle 1 after value 16'h00AB → display holds AB until hold expiry, then IDLE with enables 0. With lz_blank set, enables are digits 1 and 0 only.
- lz_blank on with value 16'h0000 → only digit0_en_o=1 and digit0_o=0. value 16'h0100 → digits 2..0 enabled.
- blink on with a steady request → enables follow the pattern 1,1,0,0,1,1…. A grant switch restarts the pattern with 1,1.
- Assert rst_ni low mid-HOLD, between clock edges → outputs clear immediately. Release with req still high → regrant one cycle after the first clock edge following release.
